// File: rtl/autenticacao_controlador.sv
// autenticacao_controlador: sequences one authentication attempt through an external comparator with retry lockout
module autenticacao_controlador #(
  parameter int MAX_TRIES    = 3,
  parameter int GRANT_CYCLES = 10,
  parameter int LOCK_CYCLES  = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] CODE,
  input  logic [1:0] SEL,
  input  logic       AUT1,
  input  logic       AUT2,
  input  logic       AUT3,
  output logic [5:0] CMP_CODE,
  output logic       BUSY,
  output logic       GRANT,
  output logic       DENY,
  output logic       LOCKED,
  output logic [2:0] TRIES
);
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_GRANT, ST_DENY, ST_LOCK} state_t;
  localparam logic [2:0] MAX_T   = 3'(MAX_TRIES);
  localparam logic [7:0] GRANT_T = 8'(GRANT_CYCLES - 1);
  localparam logic [7:0] LOCK_T  = 8'(LOCK_CYCLES - 1);
  state_t     state_q, state_d;
  logic [5:0] cmp_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] tries_q, tries_d;
  logic [7:0] timer_q, timer_d;
  logic       start_q, start_pulse, match;
  assign start_pulse = START & ~start_q;
  assign match  = sel_q == 2'b01 ? AUT1 : sel_q == 2'b10 ? AUT2 : sel_q == 2'b11 ? AUT3 : 1'b0;
  assign BUSY   = state_q != ST_IDLE;
  assign GRANT  = state_q == ST_GRANT;
  assign DENY   = state_q == ST_DENY;
  assign LOCKED = state_q == ST_LOCK;
  assign TRIES  = tries_q;
  // state and datapath registers; start_q resets high so a held START is not seen as an edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      CMP_CODE <= '0;
      sel_q    <= '0;
      tries_q  <= '0;
      timer_q  <= '0;
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      CMP_CODE <= cmp_d;
      sel_q    <= sel_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
      start_q  <= START;
    end
  end
  // next-state, capture, failure counting and timer control
  always_comb begin
    state_d = state_q;
    cmp_d   = CMP_CODE;
    sel_d   = sel_q;
    tries_d = tries_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: if (start_pulse) begin
        cmp_d   = CODE;
        sel_d   = SEL;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_CHECK;
      ST_CHECK: if (match) begin
        tries_d = '0;
        timer_d = GRANT_T;
        state_d = ST_GRANT;
      end else if (tries_q + 3'd1 == MAX_T) begin
        tries_d = MAX_T;
        timer_d = LOCK_T;
        state_d = ST_LOCK;
      end else begin
        tries_d = tries_q + 3'd1;
        state_d = ST_DENY;
      end
      ST_GRANT: if (timer_q == '0) state_d = ST_IDLE; else timer_d = timer_q - 8'd1;
      ST_DENY: state_d = ST_IDLE;
      ST_LOCK: if (timer_q == '0) begin
        tries_d = '0;
        state_d = ST_IDLE;
      end else timer_d = timer_q - 8'd1;
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_autenticacao_controlador.sv
// tb_autenticacao_controlador: directed scoreboard bench for the authentication controller
module tb_autenticacao_controlador;
  logic       CLK = 0, RST = 1, START = 1;
  logic [5:0] CODE = '0;
  logic [1:0] SEL = '0;
  logic       AUT1 = 1, AUT2 = 0, AUT3 = 0;
  logic [5:0] CMP_CODE;
  logic       BUSY, GRANT, DENY, LOCKED;
  logic [2:0] TRIES;
  int total = 0, bad = 0;
  typedef struct {int kind; int len; int tries_in; int tries_after;} ev_t;
  ev_t exp_q[$];
  int cur_kind = 0, cur_len = 0, cur_tries = 0;

  autenticacao_controlador dut (
    .CLK(CLK), .RST(RST), .START(START), .CODE(CODE), .SEL(SEL),
    .AUT1(AUT1), .AUT2(AUT2), .AUT3(AUT3), .CMP_CODE(CMP_CODE),
    .BUSY(BUSY), .GRANT(GRANT), .DENY(DENY), .LOCKED(LOCKED), .TRIES(TRIES)
  );

  always #5 CLK = ~CLK;

  function automatic int kind_now();
    return GRANT ? 1 : DENY ? 2 : LOCKED ? 3 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor: measures each GRANT/DENY/LOCKED pulse and checks it against the scoreboard
  always @(negedge CLK) begin
    int k;
    ev_t e;
    k = kind_now();
    if (RST) cur_kind = 0;
    else if (k != 0 && cur_kind == 0) begin
      cur_kind = k; cur_len = 1; cur_tries = int'(TRIES);
    end else if (k != 0 && k == cur_kind) cur_len++;
    else if (cur_kind != 0) begin
      if (exp_q.size() == 0) chk("unexpected_event", cur_kind, 0);
      else begin
        e = exp_q.pop_front();
        chk("ev_kind", cur_kind, e.kind);
        chk("ev_len", cur_len, e.len);
        chk("ev_tries", cur_tries, e.tries_in);
        chk("ev_tries_after", int'(TRIES), e.tries_after);
      end
      cur_kind = k; cur_len = 1; cur_tries = int'(TRIES);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300 && BUSY; i++) @(negedge CLK);
    chk("idle_timeout", int'(BUSY), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_grant"}, int'(GRANT), 0);
    chk({tag, "_deny"}, int'(DENY), 0);
    chk({tag, "_locked"}, int'(LOCKED), 0);
    chk({tag, "_tries"}, int'(TRIES), 0);
    chk({tag, "_cmp"}, int'(CMP_CODE), 0);
  endtask

  // one attempt: kind 1=grant 2=deny 3=lock; abort>0 resets asynchronously that many cycles into the result
  task automatic run(input logic [5:0] code, input logic [1:0] sel, input int kind, input int len,
                     input int tin, input int tafter, input int pokes, input int abort);
    ev_t e;
    if (abort == 0) begin
      e.kind = kind; e.len = len; e.tries_in = tin; e.tries_after = tafter;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    CODE = code; SEL = sel; START = 1;
    @(negedge CLK);
    START = 0;
    chk("cmp_after_k", int'(CMP_CODE), int'(code));
    chk("busy_after_k", int'(BUSY), 1);
    CODE = ~code; SEL = 2'b00;
    @(negedge CLK);
    chk("quiet_after_k1", kind_now(), 0);
    @(negedge CLK);
    chk("result_after_k2", kind_now(), kind);
    for (int i = 0; i < pokes; i++) begin
      START = 1; @(negedge CLK);
      START = 0; @(negedge CLK);
    end
    if (abort > 0) begin
      repeat (abort) @(negedge CLK);
      #2 RST = 1;
      #1 check_reset_outputs("async_rst");
      @(negedge CLK);
      #2 RST = 0;
    end else begin
      wait_idle();
      chk("cmp_held", int'(CMP_CODE), int'(code));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12 check_reset_outputs("reset");
    @(negedge CLK);
    #2 RST = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("held_start_no_busy", int'(BUSY), 0);
    end
    START = 0;
    run(6'b000000, 2'b01, 1, 10, 0, 0, 0, 0);
    run(6'b000000, 2'b10, 2, 1, 1, 1, 0, 0);
    run(6'b101101, 2'b10, 2, 1, 2, 2, 0, 0);
    run(6'b010010, 2'b10, 3, 50, 3, 0, 5, 0);
    run(6'b111111, 2'b01, 1, 10, 0, 0, 1, 0);
    run(6'b000001, 2'b10, 2, 1, 1, 1, 0, 0);
    run(6'b000010, 2'b10, 2, 1, 2, 2, 0, 0);
    AUT3 = 1;
    run(6'b100000, 2'b11, 1, 10, 0, 0, 0, 0);
    AUT3 = 0;
    run(6'b011011, 2'b10, 2, 1, 1, 1, 0, 0);
    AUT1 = 1; AUT2 = 1; AUT3 = 1;
    run(6'b110011, 2'b00, 2, 1, 2, 2, 0, 0);
    AUT2 = 0; AUT3 = 0;
    run(6'b001100, 2'b10, 3, 50, 3, 0, 0, 0);
    run(6'b000111, 2'b01, 1, 10, 0, 0, 0, 4);
    run(6'b000011, 2'b10, 2, 1, 1, 1, 0, 0);
    run(6'b000011, 2'b10, 2, 1, 2, 2, 0, 0);
    run(6'b010101, 2'b10, 3, 50, 3, 0, 0, 10);
    run(6'b101010, 2'b10, 2, 1, 1, 1, 0, 0);
    run(6'b000000, 2'b01, 1, 10, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
